pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/call/return PC selection with a
// circular return-address stack, stall hold and a terminal HALT state.
module pc_sequencer #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned OFF_W     = 9,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [2:0]        op,
  input  logic [2:0]        cond,
  input  logic [2:0]        flags,
  input  logic [OFF_W-1:0]  offset,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              redirect,
  output logic              halted,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_B    = 3'b001;
  localparam logic [2:0] OP_BR   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HLT  = 3'b101;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0]   ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                redirect_q, redirect_d;
  logic                halted_q, halted_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic [ADDR_W-1:0]   seq_c, btgt_c, off_ext_c;
  logic [PTR_W-1:0]    top_ptr_c;
  logic                cond_true_c;
  logic                z_c, v_c, n_c;

  assign z_c = flags[0];
  assign v_c = flags[1];
  assign n_c = flags[2];

  // Sequential and branch targets, both wrapping modulo 2^ADDR_W
  assign off_ext_c = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign seq_c     = pc_q + ADDR_W'(2);
  assign btgt_c    = seq_c + (off_ext_c << 1);
  assign top_ptr_c = wr_ptr_q - PTR_W'(1);

  // Branch condition decode
  always_comb begin
    cond_true_c = 1'b0;
    case (cond)
      3'b000:  cond_true_c = !z_c;
      3'b001:  cond_true_c = z_c;
      3'b010:  cond_true_c = !z_c && !n_c;
      3'b011:  cond_true_c = n_c;
      3'b100:  cond_true_c = z_c || (!z_c && !n_c);
      3'b101:  cond_true_c = z_c || n_c;
      3'b110:  cond_true_c = v_c;
      default: cond_true_c = 1'b1;
    endcase
  end

  // Next-state: op commit in RUN, hold on stall or in HALT
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ras_d      = ras_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    redirect_d = 1'b0;
    if (state_q == ST_RUN && !stall) begin
      case (op)
        OP_B: begin
          pc_d       = cond_true_c ? btgt_c : seq_c;
          redirect_d = cond_true_c;
        end
        OP_BR: begin
          pc_d       = cond_true_c ? target : seq_c;
          redirect_d = cond_true_c;
        end
        OP_CALL: begin
          pc_d            = btgt_c;
          redirect_d      = 1'b1;
          ras_d[wr_ptr_q] = seq_c;
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
          // Full stack: the write pointer already sits on the oldest entry
          if (cnt_q == CNT_W'(RAS_DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        OP_RET: begin
          if (cnt_q == '0) begin
            pc_d  = seq_c;
            unf_d = 1'b1;
          end else begin
            pc_d       = ras_q[top_ptr_c];
            wr_ptr_d   = top_ptr_c;
            cnt_d      = cnt_q - CNT_W'(1);
            redirect_d = 1'b1;
          end
        end
        OP_HLT:  state_d = ST_HALT;
        default: pc_d = seq_c;
      endcase
    end
    halted_d = (state_d == ST_HALT);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, stack and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= ADDR_W'(RESET_PC);
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
      halted_q   <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ras_q      <= ras_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      halted_q   <= halted_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign pc       = pc_q;
  assign redirect = redirect_q;
  assign halted   = halted_q;
  assign ras_ovf  = ovf_q;
  assign ras_unf  = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected PCs and flags.
module tb_pc_sequencer;

  localparam logic [2:0] SEQ  = 3'b000;
  localparam logic [2:0] B    = 3'b001;
  localparam logic [2:0] BR   = 3'b010;
  localparam logic [2:0] CALL = 3'b011;
  localparam logic [2:0] RET  = 3'b100;
  localparam logic [2:0] HLT  = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [2:0]  op, cond, flags;
  logic [8:0]  offset;
  logic [15:0] target;
  logic [15:0] pc;
  logic        redirect, halted, ras_ovf, ras_unf;

  int n_assert = 0;
  int n_fail   = 0;

  pc_sequencer #(.ADDR_W(16), .OFF_W(9), .RAS_DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .op(op), .cond(cond),
    .flags(flags), .offset(offset), .target(target), .pc(pc),
    .redirect(redirect), .halted(halted), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [2:0] c, input logic [2:0] f,
                       input logic [8:0] off, input logic [15:0] tgt, input logic st);
    op = o; cond = c; flags = f; offset = off; target = tgt; stall = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input string tag, input logic [15:0] p, input logic r);
    chk({tag, "_pc"}, 32'(pc), 32'(p));
    chk({tag, "_redir"}, 32'(redirect), 32'(r));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(SEQ, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b0);
    step();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_redir", 32'(redirect), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_ovf", 32'(ras_ovf), 32'h0);
    chk("rst_unf", 32'(ras_unf), 32'h0);
    rst_n = 1'b1;

    // Sequential stepping
    step(); expect_pc("seq1", 16'h0002, 1'b0);
    step(); expect_pc("seq2", 16'h0004, 1'b0);
    step(); expect_pc("seq3", 16'h0006, 1'b0);

    // Conditional branches
    drive(BR, 3'b111, 3'b000, 9'h000, 16'h0010, 1'b0); step(); expect_pc("br10", 16'h0010, 1'b1);
    drive(B, 3'b001, 3'b001, 9'h1FE, 16'h0000, 1'b0); step(); expect_pc("b_z1", 16'h000E, 1'b1);
    drive(BR, 3'b111, 3'b000, 9'h000, 16'h0010, 1'b0); step(); expect_pc("br10b", 16'h0010, 1'b1);
    drive(B, 3'b001, 3'b000, 9'h1FE, 16'h0000, 1'b0); step(); expect_pc("b_z0", 16'h0012, 1'b0);
    drive(B, 3'b011, 3'b100, 9'h004, 16'h0000, 1'b0); step(); expect_pc("b_n", 16'h001C, 1'b1);
    drive(B, 3'b100, 3'b100, 9'h004, 16'h0000, 1'b0); step(); expect_pc("b_c4f", 16'h001E, 1'b0);
    drive(B, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b0); step(); expect_pc("b_nz", 16'h0020, 1'b1);
    drive(B, 3'b101, 3'b000, 9'h004, 16'h0000, 1'b0); step(); expect_pc("b_c5f", 16'h0022, 1'b0);
    drive(B, 3'b110, 3'b010, 9'h001, 16'h0000, 1'b0); step(); expect_pc("b_v", 16'h0026, 1'b1);
    drive(B, 3'b010, 3'b100, 9'h004, 16'h0000, 1'b0); step(); expect_pc("b_c2f", 16'h0028, 1'b0);
    drive(B, 3'b100, 3'b000, 9'h002, 16'h0000, 1'b0); step(); expect_pc("b_c4t", 16'h002E, 1'b1);

    // Wraparound
    drive(BR, 3'b111, 3'b000, 9'h000, 16'hFFFE, 1'b0); step(); expect_pc("brFE", 16'hFFFE, 1'b1);
    drive(SEQ, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b0); step(); expect_pc("seq_wrap", 16'h0000, 1'b0);
    drive(BR, 3'b111, 3'b000, 9'h000, 16'hFFFC, 1'b0); step(); expect_pc("brFC", 16'hFFFC, 1'b1);
    drive(B, 3'b111, 3'b000, 9'h001, 16'h0000, 1'b0); step(); expect_pc("b_wrap", 16'h0000, 1'b1);

    // Unaligned and not-taken register branches; 110/111 as SEQ
    drive(BR, 3'b111, 3'b000, 9'h000, 16'h0101, 1'b0); step(); expect_pc("br_unal", 16'h0101, 1'b1);
    drive(BR, 3'b001, 3'b000, 9'h000, 16'h0500, 1'b0); step(); expect_pc("br_nt", 16'h0103, 1'b0);
    drive(3'b111, 3'b111, 3'b000, 9'h010, 16'h0500, 1'b0); step(); expect_pc("op111", 16'h0105, 1'b0);
    drive(BR, 3'b111, 3'b000, 9'h000, 16'h0100, 1'b0); step(); expect_pc("br100", 16'h0100, 1'b1);

    // Five calls into a four-deep stack, then five returns
    drive(CALL, 3'b000, 3'b000, 9'h008, 16'h0000, 1'b0);
    step(); expect_pc("call1", 16'h0112, 1'b1);
    step(); expect_pc("call2", 16'h0124, 1'b1);
    step(); expect_pc("call3", 16'h0136, 1'b1);
    step(); expect_pc("call4", 16'h0148, 1'b1);
    chk("ovf_before", 32'(ras_ovf), 32'h0);
    step(); expect_pc("call5", 16'h015A, 1'b1);
    chk("ovf_after", 32'(ras_ovf), 32'h1);
    drive(RET, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b0);
    step(); expect_pc("ret1", 16'h014A, 1'b1);
    step(); expect_pc("ret2", 16'h0138, 1'b1);
    step(); expect_pc("ret3", 16'h0126, 1'b1);
    step(); expect_pc("ret4", 16'h0114, 1'b1);
    chk("unf_before", 32'(ras_unf), 32'h0);
    step(); expect_pc("ret5", 16'h0116, 1'b0);
    chk("unf_after", 32'(ras_unf), 32'h1);
    chk("ovf_sticky", 32'(ras_ovf), 32'h1);

    // Stall holds, then commits
    drive(BR, 3'b111, 3'b000, 9'h000, 16'h0420, 1'b1);
    step(); expect_pc("stall1", 16'h0116, 1'b0);
    step(); expect_pc("stall2", 16'h0116, 1'b0);
    stall = 1'b0;
    step(); expect_pc("br420", 16'h0420, 1'b1);
    drive(HLT, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b1);
    step(); expect_pc("stall_hlt", 16'h0420, 1'b0);
    chk("stall_hlt_halted", 32'(halted), 32'h0);
    drive(CALL, 3'b000, 3'b000, 9'h004, 16'h0000, 1'b1);
    step(); expect_pc("stall_call", 16'h0420, 1'b0);
    // A stalled CALL must not have pushed: the next RET still underflows
    drive(RET, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b0);
    step(); expect_pc("ret_empty", 16'h0422, 1'b0);

    // HALT
    drive(BR, 3'b111, 3'b000, 9'h000, 16'h0030, 1'b0); step(); expect_pc("br30", 16'h0030, 1'b1);
    drive(HLT, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b0); step(); expect_pc("hlt", 16'h0030, 1'b0);
    chk("hlt_halted", 32'(halted), 32'h1);
    for (int i = 0; i < 10; i++) begin
      drive(3'($urandom_range(0, 7)), 3'b111, 3'($urandom), 9'($urandom), 16'($urandom),
            1'($urandom));
      step();
      expect_pc("halt_hold", 16'h0030, 1'b0);
      chk("halt_halted", 32'(halted), 32'h1);
    end
    chk("halt_ovf", 32'(ras_ovf), 32'h1);
    chk("halt_unf", 32'(ras_unf), 32'h1);

    // Asynchronous reset mid-cycle
    drive(SEQ, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_ovf", 32'(ras_ovf), 32'h0);
    chk("arst_unf", 32'(ras_unf), 32'h0);
    chk("arst_redir", 32'(redirect), 32'h0);
    #2 rst_n = 1'b1;
    step(); expect_pc("post_rst", 16'h0002, 1'b0);
    chk("post_rst_halted", 32'(halted), 32'h0);
    drive(RET, 3'b000, 3'b000, 9'h000, 16'h0000, 1'b0);
    step(); expect_pc("post_rst_ret", 16'h0004, 1'b0);
    chk("post_rst_unf", 32'(ras_unf), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
